dpll_trim_ctrl: RTL and testbench
=================================

DPLL_TRIM_CTRL -- requirements
Module: dpll_trim_ctrl

Interface
REQ-001 SHALL have parameter TRIM_W, default 26: oscillator trim width.
REQ-002 SHALL have parameter CNT_W, default 8: period counter width.
REQ-003 SHALL have parameter TOL, default 1: dead-band half-width, in clock cycles.
REQ-004 SHALL have parameter LOCK_N, default 4: consecutive in-band measurements required to assert lock.
REQ-005 SHALL have port clock, input, 1: the ring-oscillator output (clockp[0]); the only clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1: loop enable; when low, trim is held.
REQ-008 SHALL have port ref_clk, input, 1: external reference, asynchronous to clock.
REQ-009 SHALL have port div, input, CNT_W: target clock cycles per ref_clk period.
REQ-010 SHALL have port trim, output, TRIM_W: thermometer code driven to ring_osc2x13.trim.
REQ-011 SHALL have port tval, output, $clog2(TRIM_W+1): binary count of ones in trim.
REQ-012 SHALL have port locked, output, 1: frequency lock flag.

Function
REQ-013 SHALL synchronise ref_clk through 2 flops, then register it once more for edge detection.
- A ref rising edge is "detected" in the clock cycle where the 2nd sync flop is 1 and the edge flop is 0.
REQ-014 SHALL hold a period counter cnt with these rules:
- cleared to 1 in every detected-edge cycle;
- otherwise incremented by 1 per clock, saturating at 2^CNT_W-1.
REQ-015 SHALL define the measured period P as cnt sampled in a detected-edge cycle, before it is cleared.
REQ-016 SHALL use an FSM with three states: IDLE, ARM, TRACK.
REQ-017 FSM transitions SHALL be:
- IDLE -> ARM when enable=1;
- ARM -> TRACK on the first detected edge, with P discarded;
- TRACK evaluates every detected edge;
- any state -> IDLE when enable=0, effective next cycle.
REQ-018 In TRACK, on each detected edge, SHALL compare P against div using unsigned CNT_W+1-bit arithmetic:
- P > div+TOL (oscillator fast): tval <= tval+1, saturating at TRIM_W;
- P+TOL < div (oscillator slow): tval <= tval-1, saturating at 0;
- otherwise: tval unchanged.
REQ-019 tval and trim SHALL update exactly one clock after the detected-edge cycle and at no other time.
REQ-020 trim SHALL equal (1<<tval)-1: bits [tval-1:0] set, remaining bits clear, registered.
REQ-021 SHALL keep a lock counter lcnt:
- incremented, saturating at LOCK_N, on each in-band evaluation;
- cleared on each out-of-band evaluation;
- cleared on entry to IDLE.
REQ-022 locked SHALL be 1 iff lcnt==LOCK_N and state==TRACK.
REQ-023 A saturated tval, whether at TRIM_W or at 0, SHALL count as out-of-band for lock while the error persists.
REQ-024 If ref_clk stops, cnt SHALL saturate and no evaluation occurs; trim SHALL hold and locked SHALL hold.
REQ-025 A div change SHALL take effect at the next evaluation, with no other side effect.
REQ-026 In IDLE, trim and tval SHALL hold their last values.

Reset
REQ-027 On reset assertion, SHALL set immediately, without waiting for a clock:
- state=IDLE;
- tval=TRIM_W/2 (13);
- trim=0x0001FFF;
- cnt=0, lcnt=0, locked=0;
- all sync flops=0.
REQ-028 A reset asserted mid-TRACK SHALL override all other updates in the same cycle.

Structure
REQ-029 Package dpll_pkg SHALL hold:
- the state enum {IDLE, ARM, TRACK};
- default constants TRIM_W=26, CNT_W=8.
REQ-030 The 2-flop synchroniser SHALL be a separate sub-module dpll_sync2, with reset clearing both flops.
REQ-031 The FSM, counters, comparator and thermometer encoder SHALL live in dpll_trim_ctrl.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Reset: assert reset with no clock running -> trim=0x0001FFF, tval=13, locked=0.
- Fast oscillator: div=100, ref period 110 clocks, enable=1 -> first edge ignored; each later edge tval +1, reaching 26 and holding; trim=0x3FFFFFF; locked stays 0.
- Slow oscillator: div=100, ref period 90 clocks -> tval decrements to 0, trim=0, and holds.
- Lock: div=100, ref period 100 clocks -> tval stays 13; locked rises one clock after the 4th evaluated edge.
- Lock loss: ref period jumps from 100 to 103 clocks -> locked falls and tval becomes 14, both one clock after the next detected edge.
- Interruptions:
  - enable=0 mid-TRACK -> trim frozen, locked=0;
  - reset pulse mid-TRACK -> immediate return to tval=13;
  - ref_clk stopped -> cnt saturates at 255 and trim is unchanged.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared types and default widths for the DPLL trim controller.
package dpll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TRACK
  } state_e;

  localparam int unsigned TRIM_W_DEF = 26;
  localparam int unsigned CNT_W_DEF  = 8;

endpackage

// File: rtl/dpll_sync2.sv
// Two-flop synchroniser bringing the asynchronous reference into the clock domain.
module dpll_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/dpll_trim_ctrl.sv
// Frequency-locking trim controller: measures oscillator cycles per reference
// period and steps a thermometer-coded trim toward the target count.
module dpll_trim_ctrl
  import dpll_pkg::*;
#(
  parameter int unsigned TRIM_W = TRIM_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned TOL    = 1,
  parameter int unsigned LOCK_N = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          ref_clk,
  input  logic [CNT_W-1:0]              div,
  output logic [TRIM_W-1:0]             trim,
  output logic [$clog2(TRIM_W+1)-1:0]   tval,
  output logic                          locked
);

  localparam int unsigned TV_W = $clog2(TRIM_W + 1);
  localparam int unsigned LC_W = $clog2(LOCK_N + 1);
  localparam int unsigned CW1  = CNT_W + 1;

  localparam logic [TV_W-1:0]  TV_MAX  = TV_W'(TRIM_W);
  localparam logic [TV_W-1:0]  TV_RST  = TV_W'(TRIM_W / 2);
  localparam logic [TV_W-1:0]  TV_ONE  = TV_W'(1);
  localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_N);
  localparam logic [LC_W-1:0]  LC_ONE  = LC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CW1-1:0]   TOL_X   = CW1'(TOL);

  function automatic logic [TRIM_W-1:0] therm(input logic [TV_W-1:0] n);
    logic [TRIM_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < TRIM_W; i++) t[i] = (i < 32'(n));
    return t;
  endfunction

  logic ref_s, ref_e_q, ref_e_d, edge_det;

  dpll_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (ref_clk),
    .q     (ref_s)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TV_W-1:0]   tval_q, tval_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic              locked_q, locked_d;
  logic [CW1-1:0]    p_x, div_x;
  logic              fast, slow;

  assign edge_det = ref_s & ~ref_e_q;
  assign p_x      = {1'b0, cnt_q};
  assign div_x    = {1'b0, div};
  assign fast     = p_x > (div_x + TOL_X);
  assign slow     = (p_x + TOL_X) < div_x;

  always_comb begin
    ref_e_d = ref_s;
    state_d = state_q;
    tval_d  = tval_q;
    lcnt_d  = lcnt_q;
    cnt_d   = edge_det ? CNT_ONE : ((cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE);

    // Dropping enable wins over any evaluation in the same cycle, freezing trim.
    if (!enable) begin
      state_d = IDLE;
      lcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = ARM;
        ARM:   if (edge_det) state_d = TRACK;
        TRACK: begin
          if (edge_det) begin
            if (fast) begin
              if (tval_q != TV_MAX) tval_d = tval_q + TV_ONE;
              lcnt_d = '0;
            end else if (slow) begin
              if (tval_q != '0) tval_d = tval_q - TV_ONE;
              lcnt_d = '0;
            end else if (lcnt_q != LC_MAX) begin
              lcnt_d = lcnt_q + LC_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    trim_d   = therm(tval_d);
    locked_d = (lcnt_d == LC_MAX) && (state_d == TRACK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_e_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      tval_q   <= TV_RST;
      trim_q   <= therm(TV_RST);
      lcnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      ref_e_q  <= ref_e_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tval_q   <= tval_d;
      trim_q   <= trim_d;
      lcnt_q   <= lcnt_d;
      locked_q <= locked_d;
    end
  end

  assign trim   = trim_q;
  assign tval   = tval_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_dpll_trim_ctrl.sv
// Directed bench for dpll_trim_ctrl: vector table of steady-state outcomes plus
// cycle-exact sequences for lock, lock loss, enable drop, reset and ref stop.
module tb_dpll_trim_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        ref_clk;
  logic [7:0]  div;
  logic [25:0] trim;
  logic [4:0]  tval;
  logic        locked;

  int n_vec = 0;
  int n_bad = 0;

  int unsigned ref_period = 100;
  int unsigned ref_ph     = 0;
  int unsigned ref_rises  = 0;
  bit          ref_run    = 0;
  bit          clk_on     = 0;

  dpll_trim_ctrl #(.TRIM_W(26), .CNT_W(8), .TOL(1), .LOCK_N(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .ref_clk (ref_clk),
    .div     (div),
    .trim    (trim),
    .tval    (tval),
    .locked  (locked)
  );

  initial begin
    clock = 1'b0;
    wait (clk_on);
    forever #5 clock = ~clock;
  end

  // Reference generator: one rise every ref_period clocks, high for half of it.
  initial begin
    ref_clk = 1'b0;
    forever begin
      @(negedge clock);
      if (ref_run) begin
        if (ref_ph == 0) ref_rises++;
        ref_clk = (ref_ph < ref_period / 2);
        ref_ph++;
        if (ref_ph >= ref_period) ref_ph = 0;
      end else begin
        ref_clk = 1'b0;
        ref_ph  = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input int unsigned et,
                           input logic [25:0] etrim, input logic el);
    check({name, ".tval"},   32'(tval),   32'(et));
    check({name, ".trim"},   32'(trim),   32'(etrim));
    check({name, ".locked"}, 32'(locked), 32'(el));
  endtask

  // Returns on the first rising clock after the n-th further reference rise.
  task automatic wait_rises(input int unsigned n);
    int unsigned tgt;
    int unsigned budget;
    tgt    = ref_rises + n;
    budget = 0;
    while (ref_rises < tgt && budget < n * 400 + 10) begin
      @(posedge clock);
      budget++;
    end
    if (ref_rises < tgt) begin
      n_vec++;
      n_bad++;
      $display("FAIL ref_wait: got %0d rises expected %0d", ref_rises, tgt);
    end
  endtask

  task automatic start_run(input int unsigned d, input int unsigned p);
    @(posedge clock);
    #1;
    enable  = 1'b0;
    ref_run = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset      = 1'b0;
    div        = 8'(d);
    ref_period = p;
    @(posedge clock);
    #1;
    enable  = 1'b1;
    ref_run = 1'b1;
  endtask

  typedef struct {
    int unsigned d;
    int unsigned period;
    int unsigned rises;
    int unsigned exp_tval;
    logic [25:0] exp_trim;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[16];

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    div    = 8'd100;

    vecs[0]  = '{100, 110,  1, 13, 26'h0001FFF, 1'b0};
    vecs[1]  = '{100, 110,  2, 14, 26'h0003FFF, 1'b0};
    vecs[2]  = '{100, 110,  5, 17, 26'h001FFFF, 1'b0};
    vecs[3]  = '{100, 110, 16, 26, 26'h3FFFFFF, 1'b0};
    vecs[4]  = '{100, 110, 20, 26, 26'h3FFFFFF, 1'b0};
    vecs[5]  = '{100,  90,  2, 12, 26'h0000FFF, 1'b0};
    vecs[6]  = '{100,  90, 16,  0, 26'h0000000, 1'b0};
    vecs[7]  = '{100,  90, 20,  0, 26'h0000000, 1'b0};
    vecs[8]  = '{100, 100,  4, 13, 26'h0001FFF, 1'b0};
    vecs[9]  = '{100, 100,  5, 13, 26'h0001FFF, 1'b1};
    vecs[10] = '{100, 101,  6, 13, 26'h0001FFF, 1'b1};
    vecs[11] = '{100,  99,  6, 13, 26'h0001FFF, 1'b1};
    vecs[12] = '{100, 102,  3, 15, 26'h0007FFF, 1'b0};
    vecs[13] = '{100,  98,  3, 11, 26'h00007FF, 1'b0};
    vecs[14] = '{255, 300,  6, 13, 26'h0001FFF, 1'b1};
    vecs[15] = '{ 20,  30,  3, 15, 26'h0007FFF, 1'b0};

    // Reset with no clock running.
    #1 reset = 1'b1;
    #1 check_out("async_reset", 13, 26'h0001FFF, 1'b0);
    #3 clk_on = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start_run(vecs[i].d, vecs[i].period);
      wait_rises(vecs[i].rises);
      repeat (vecs[i].period / 2) @(posedge clock);
      #1 check_out($sformatf("vec%0d", i), vecs[i].exp_tval, vecs[i].exp_trim, vecs[i].exp_locked);
    end

    // Lock rises exactly one clock after the 4th evaluated edge, then lock loss.
    start_run(100, 100);
    wait_rises(5);
    @(posedge clock);
    #1 check("lock_pre", 32'(locked), 32'd0);
    @(posedge clock);
    #1 check("lock_post", 32'(locked), 32'd1);
    wait_rises(1);
    ref_period = 103;
    wait_rises(1);
    @(posedge clock);
    #1 check_out("loss_pre", 13, 26'h0001FFF, 1'b1);
    @(posedge clock);
    #1 check_out("loss_post", 14, 26'h0003FFF, 1'b0);

    // Enable dropped while locked, then oscillator goes fast: trim stays frozen.
    start_run(100, 100);
    wait_rises(6);
    repeat (50) @(posedge clock);
    #1 enable = 1'b0;
    repeat (2) @(posedge clock);
    #1 check_out("en_drop", 13, 26'h0001FFF, 1'b0);
    wait_rises(1);
    ref_period = 110;
    wait_rises(3);
    repeat (55) @(posedge clock);
    #1 check_out("en_frozen", 13, 26'h0001FFF, 1'b0);

    // Reset pulse mid-TRACK takes effect before the next clock edge.
    start_run(100, 110);
    wait_rises(5);
    repeat (20) @(posedge clock);
    #1 check_out("pre_rst", 17, 26'h001FFFF, 1'b0);
    #1 reset = 1'b1;
    #1 check_out("mid_rst", 13, 26'h0001FFF, 1'b0);
    @(negedge clock) reset = 1'b0;

    // Reference stops: counter saturates, trim and lock hold; restart sees P=255.
    start_run(100, 100);
    wait_rises(6);
    repeat (50) @(posedge clock);
    #1 ref_run = 1'b0;
    repeat (400) @(posedge clock);
    #1 check("cnt_sat", 32'(dut.cnt_q), 32'd255);
    check_out("ref_stop", 13, 26'h0001FFF, 1'b1);
    ref_run = 1'b1;
    wait_rises(1);
    repeat (50) @(posedge clock);
    #1 check_out("ref_restart", 14, 26'h0003FFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
